// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Multicycle stage sequencer for the RISC core. Holds the IF/ID/EX/MEM/WB
// stage register, works out the per-opcode path through the stages, produces
// the IR/PC write strobes for the datapath and counts retired instructions.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   synchronous active-high reset
//   OP[5:0]     in   opcode field of the instruction register (valid from ID)
//   imem_ready  in   instruction memory has valid data this cycle
//   dmem_ready  in   data memory access completes this cycle
//   hold        in   freeze sequencing (debug / external stall)
//   state       out  current stage (registered)
//   next_state  out  stage entered at the next posedge (combinational)
//   IRWrite     out  latch the instruction register at the next posedge
//   PCWrite     out  update the PC at the next posedge (end of instruction)
//   illegal_op  out  one-cycle registered pulse after an undefined opcode
//   retired     out  count of completed legal instructions (wraps)
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             hold,
    output logic [2:0]       state,
    output logic [2:0]       next_state,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    // Stage encoding; 101..111 are unreachable and recover to IF.
    localparam logic [2:0] ST_IF  = 3'b000;
    localparam logic [2:0] ST_ID  = 3'b001;
    localparam logic [2:0] ST_EX  = 3'b010;
    localparam logic [2:0] ST_MEM = 3'b011;
    localparam logic [2:0] ST_WB  = 3'b100;

    // Path classes: each opcode maps onto one of these stage sequences.
    localparam logic [2:0] P_ALU   = 3'd0;  // ID EX WB
    localparam logic [2:0] P_LOAD  = 3'd1;  // ID EX MEM WB
    localparam logic [2:0] P_STORE = 3'd2;  // ID EX MEM
    localparam logic [2:0] P_BR    = 3'd3;  // ID EX
    localparam logic [2:0] P_JMP   = 3'd4;  // ID
    localparam logic [2:0] P_PUSH  = 3'd5;  // ID MEM
    localparam logic [2:0] P_POP   = 3'd6;  // ID MEM WB
    localparam logic [2:0] P_ILL   = 3'd7;  // ID, flagged illegal

    function automatic logic [2:0] decode_path(input logic [5:0] op);
        logic [2:0] p;
        case (op)
            6'b000000, 6'b000001, 6'b000010,
            6'b000011, 6'b000100:             p = P_ALU;
            6'b000101, 6'b000110:             p = P_LOAD;
            6'b000111:                        p = P_STORE;
            6'b001000, 6'b001001,
            6'b001010, 6'b001011:             p = P_BR;
            6'b001100:                        p = P_JMP;
            6'b001101, 6'b001111:             p = P_PUSH;
            6'b001110, 6'b010000:             p = P_POP;
            default:                          p = P_ILL;
        endcase
        return p;
    endfunction

    logic [2:0]       state_q, state_d;
    logic             illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [2:0]       path;
    logic             ir_write, pc_write, retire;

    assign path = decode_path(OP);

    // State register plus the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IF;
            illegal_op_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            retired_q    <= retired_d;
        end
    end

    // Next-stage logic. Reset beats hold, hold beats the ready inputs.
    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:  state_d = imem_ready ? ST_ID : ST_IF;
            ST_ID: begin
                case (path)
                    P_ALU, P_LOAD, P_STORE, P_BR: state_d = ST_EX;
                    P_PUSH, P_POP:                state_d = ST_MEM;
                    default:                      state_d = ST_IF;
                endcase
            end
            ST_EX: begin
                case (path)
                    P_ALU:           state_d = ST_WB;
                    P_LOAD, P_STORE: state_d = ST_MEM;
                    default:         state_d = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (!dmem_ready)
                    state_d = ST_MEM;
                else if (path == P_LOAD || path == P_POP)
                    state_d = ST_WB;
                else
                    state_d = ST_IF;
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
        if (hold)
            state_d = state_q;
        if (rst)
            state_d = ST_IF;
    end

    // Strobes and the inputs of the status registers.
    always_comb begin
        ir_write = (state_q == ST_IF) && imem_ready && !hold && !rst;
        pc_write = (state_d == ST_IF) && (state_q != ST_IF) && !hold && !rst;
        // Only real stages retire; an undefined opcode leaves ID with PCWrite
        // (so the PC skips it) but must not be counted.
        retire   = pc_write && (state_q <= ST_WB) &&
                   !((state_q == ST_ID) && (path == P_ILL));
        illegal_op_d = (state_q == ST_ID) && (path == P_ILL) && !hold && !rst;
        retired_d    = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    assign state      = state_q;
    assign next_state = state_d;
    assign IRWrite    = ir_write;
    assign PCWrite    = pc_write;
    assign illegal_op = illegal_op_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer. A second instance with a 3-bit counter
// shares all inputs so that counter wrap-around is reachable in a few JMPs.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OP;
    logic        imem_ready;
    logic        dmem_ready;
    logic        hold;

    logic [2:0]  state, next_state;
    logic        IRWrite, PCWrite, illegal_op;
    logic [31:0] retired;

    logic [2:0]  s_state, s_next_state;
    logic        s_IRWrite, s_PCWrite, s_illegal_op;
    logic [2:0]  s_retired;

    int errors = 0;
    int checks = 0;
    int cyc;
    int total;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .OP(OP), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .hold(hold), .state(state),
        .next_state(next_state), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .illegal_op(illegal_op), .retired(retired)
    );

    stage_sequencer #(.CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .OP(OP), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .hold(hold), .state(s_state),
        .next_state(s_next_state), .IRWrite(s_IRWrite), .PCWrite(s_PCWrite),
        .illegal_op(s_illegal_op), .retired(s_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from IF back to IF with all memories ready.
    task automatic run_instr(input logic [5:0] op, output int n);
        OP = op;
        n  = 0;
        do begin
            tick();
            n++;
        end while (state !== 3'd0 && n < 40);
    endtask

    initial begin
        rst = 1'b1; OP = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b1; hold = 1'b0;
        tick(); tick();
        #1;
        // reset state
        chk("rst_state", state, 3'd0);
        chk("rst_next", next_state, 3'd0);
        chk("rst_irw", IRWrite, 1'b0);
        chk("rst_pcw", PCWrite, 1'b0);
        chk("rst_ill", illegal_op, 1'b0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_s_ctl", {s_state, s_next_state, s_IRWrite, s_PCWrite, s_illegal_op, s_retired},
            14'd0);

        // ADD
        rst = 1'b0; OP = 6'b000001;
        #1;
        chk("add_if_state", state, 3'd0);
        chk("add_if_next", next_state, 3'd1);
        chk("add_if_irw", IRWrite, 1'b1);
        chk("add_if_pcw", PCWrite, 1'b0);
        tick();
        chk("add_id_state", state, 3'd1);
        chk("add_id_next", next_state, 3'd2);
        chk("add_id_irwpcw", {IRWrite, PCWrite}, 2'b00);
        tick();
        chk("add_ex_state", state, 3'd2);
        chk("add_ex_next", next_state, 3'd4);
        chk("add_ex_pcw", PCWrite, 1'b0);
        tick();
        chk("add_wb_state", state, 3'd4);
        chk("add_wb_next", next_state, 3'd0);
        chk("add_wb_pcw", PCWrite, 1'b1);
        tick();
        chk("add_end_state", state, 3'd0);
        chk("add_end_ret", retired, 32'd1);

        // LW with two data-memory wait cycles
        OP = 6'b000101; dmem_ready = 1'b0;
        tick(); tick(); tick();
        chk("lw_mem1_state", state, 3'd3);
        chk("lw_mem1_next", next_state, 3'd3);
        chk("lw_mem1_pcw", PCWrite, 1'b0);
        tick();
        chk("lw_mem2_state", state, 3'd3);
        chk("lw_mem2_pcw", PCWrite, 1'b0);
        tick();
        chk("lw_mem3_state", state, 3'd3);
        dmem_ready = 1'b1;
        #1;
        chk("lw_mem3_next", next_state, 3'd4);
        chk("lw_mem3_pcw", PCWrite, 1'b0);
        tick();
        chk("lw_wb_state", state, 3'd4);
        chk("lw_wb_pcw", PCWrite, 1'b1);
        tick();
        chk("lw_end_state", state, 3'd0);
        chk("lw_end_ret", retired, 32'd2);

        // Program: SW, BEQ, JMP, CALL, RET, POP
        total = 0;
        run_instr(6'b000111, cyc); chk("sw_cycles", cyc, 4); total += cyc;
        run_instr(6'b001010, cyc); chk("beq_cycles", cyc, 3); total += cyc;
        run_instr(6'b001100, cyc); chk("jmp_cycles", cyc, 2); total += cyc;
        run_instr(6'b001101, cyc); chk("call_cycles", cyc, 3); total += cyc;
        run_instr(6'b001110, cyc); chk("ret_cycles", cyc, 4); total += cyc;
        run_instr(6'b010000, cyc); chk("pop_cycles", cyc, 4); total += cyc;
        chk("prog_total", total, 20);
        chk("prog_ret", retired, 32'd8);

        // Undefined opcode
        OP = 6'b111111;
        tick();
        chk("ill_id_state", state, 3'd1);
        chk("ill_id_next", next_state, 3'd0);
        chk("ill_id_pcw", PCWrite, 1'b1);
        chk("ill_id_flag", illegal_op, 1'b0);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("ill_if_state", state, 3'd0);
        chk("ill_pulse", illegal_op, 1'b1);
        chk("ill_ret", retired, 32'd8);
        tick();
        chk("ill_pulse_end", illegal_op, 1'b0);
        chk("ill_stay_if", state, 3'd0);

        // Fresh reset, ADDI with hold in EX
        rst = 1'b1; imem_ready = 1'b1;
        tick();
        rst = 1'b0; OP = 6'b000100;
        tick(); tick();
        chk("addi_ex_state", state, 3'd2);
        hold = 1'b1;
        #1;
        chk("hold_next", next_state, 3'd2);
        chk("hold_pcw", PCWrite, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_state", state, 3'd2);
        end
        hold = 1'b0;
        #1;
        chk("unhold_next", next_state, 3'd4);
        tick();
        chk("addi_wb_pcw", PCWrite, 1'b1);
        tick();
        chk("addi_ret", retired, 32'd1);
        hold = 1'b1;
        #1;
        chk("hold_if_irw", IRWrite, 1'b0);
        chk("hold_if_next", next_state, 3'd0);
        hold = 1'b0;

        // LW aborted by reset while in MEM
        OP = 6'b000101; dmem_ready = 1'b0;
        tick(); tick(); tick();
        chk("lw_abort_mem", state, 3'd3);
        chk("lw_abort_ret_pre", retired, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_next", next_state, 3'd0);
        chk("abort_pcw", PCWrite, 1'b0);
        tick();
        chk("abort_state", state, 3'd0);
        chk("abort_ret", retired, 32'd0);
        rst = 1'b0; dmem_ready = 1'b1;

        // Counter wrap on the 3-bit instance
        for (int i = 0; i < 7; i++)
            run_instr(6'b001100, cyc);
        chk("wrap_pre_small", s_retired, 3'd7);
        chk("wrap_pre_main", retired, 32'd7);
        run_instr(6'b001100, cyc);
        chk("wrap_small", s_retired, 3'd0);
        chk("wrap_main", retired, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
